// File: rtl/inst_fetch_buffer_if.sv
// Enqueue/dequeue bundle for inst_fetch_buffer.
// The pre-decode/decode side uses the master modport and the buffer uses the slave modport.
// Instantiate with the same parameter values as the buffer it connects to.
interface inst_fetch_buffer_if #(
    parameter int DEPTH     = 32,
    parameter int ENQ_WIDTH = 8,
    parameter int DEQ_WIDTH = 4,
    parameter int FSQ_WIDTH = 4,
    parameter int OFF_WIDTH = 4
);
    localparam int NUM_W = $clog2(ENQ_WIDTH) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Enqueue side (from pre-decode)
    logic [ENQ_WIDTH-1:0]                enq_en;
    logic [NUM_W-1:0]                    enq_num;
    logic [ENQ_WIDTH-1:0][31:0]          enq_inst;
    logic [FSQ_WIDTH-1:0]                enq_fsq_idx;
    logic [ENQ_WIDTH-1:0][OFF_WIDTH-1:0] enq_offset;
    logic                                enq_ipf;
    logic                                flush;
    logic                                full;

    // Dequeue side (to decode)
    logic                                deq_ready;
    logic [DEQ_WIDTH-1:0]                deq_valid;
    logic [DEQ_WIDTH-1:0][31:0]          deq_inst;
    logic [DEQ_WIDTH-1:0][FSQ_WIDTH-1:0] deq_fsq_idx;
    logic [DEQ_WIDTH-1:0][OFF_WIDTH-1:0] deq_offset;
    logic [DEQ_WIDTH-1:0]                deq_ipf;
    logic [CNT_W-1:0]                    count;

    modport slave (
        input  enq_en, enq_num, enq_inst, enq_fsq_idx, enq_offset, enq_ipf, flush, deq_ready,
        output full, deq_valid, deq_inst, deq_fsq_idx, deq_offset, deq_ipf, count
    );

    modport master (
        output enq_en, enq_num, enq_inst, enq_fsq_idx, enq_offset, enq_ipf, flush, deq_ready,
        input  full, deq_valid, deq_inst, deq_fsq_idx, deq_offset, deq_ipf, count
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction buffer between pre-decode and decode: a circular FIFO that accepts up to
// ENQ_WIDTH instructions of one fetch block per cycle and presents up to DEQ_WIDTH in order.
// Head/tail pointers carry an extra wrap bit so count = tail - head covers 0..DEPTH.
// Optional feature: define IBUF_BYPASS_EN to let an empty buffer forward the incoming block
// straight to the decode lanes in the same cycle.
module inst_fetch_buffer #(
    parameter int DEPTH     = 32,
    parameter int ENQ_WIDTH = 8,
    parameter int DEQ_WIDTH = 4,
    parameter int FSQ_WIDTH = 4,
    parameter int OFF_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_buffer_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int NUM_W = $clog2(ENQ_WIDTH) + 1;

    // Pointers (wrap bit in the MSB) and entry storage
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [31:0]          r_inst    [DEPTH];
    logic [FSQ_WIDTH-1:0] r_fsq_idx [DEPTH];
    logic [OFF_WIDTH-1:0] r_offset  [DEPTH];
    logic                 r_ipf     [DEPTH];

    logic [PTR_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_enq_fire;
    logic                 w_bypass;
    logic [NUM_W-1:0]     w_skip;
    logic [PTR_W-1:0]     w_deq_num;
    logic [IDX_W-1:0]     w_rd_idx  [DEQ_WIDTH];
    logic [IDX_W-1:0]     w_wr_idx  [ENQ_WIDTH];
    logic [ENQ_WIDTH-1:0] w_wr_en;

    assign w_count    = r_tail - r_head;
    // Full as soon as a whole block might not fit; upstream holds its data while it is high.
    assign w_full     = w_count > PTR_W'(DEPTH - ENQ_WIDTH);
    assign w_enq_fire = (|bus.enq_en) && !w_full && !bus.flush;
    // Entries leaving storage this cycle (flush resets the pointers anyway).
    assign w_deq_num  = (w_count < PTR_W'(DEQ_WIDTH)) ? w_count : PTR_W'(DEQ_WIDTH);

`ifdef IBUF_BYPASS_EN
    // Bypass only from an empty buffer; consumed slots are never written to storage.
    assign w_bypass = (w_count == '0) && w_enq_fire;
    assign w_skip   = (w_bypass && bus.deq_ready)
                    ? ((bus.enq_num > NUM_W'(DEQ_WIDTH)) ? NUM_W'(DEQ_WIDTH) : bus.enq_num)
                    : '0;
`else
    assign w_bypass = 1'b0;
    assign w_skip   = '0;
`endif

    assign bus.full  = w_full;
    assign bus.count = w_count;

    // Compute storage read indices for each lane and write slots for each enqueue slot.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments, and every output gets a
        // default before any conditional code so no latch can be inferred.
        w_wr_en = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            w_rd_idx[k] = r_head[IDX_W-1:0] + IDX_W'(k);
        end
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            w_wr_idx[i] = r_tail[IDX_W-1:0] + IDX_W'(i) - IDX_W'(w_skip);
            w_wr_en[i]  = w_enq_fire && (NUM_W'(i) < bus.enq_num) && (NUM_W'(i) >= w_skip);
        end
    end

    // Drive the decode lanes from the oldest entries, or from the incoming block on a bypass.
    always_comb begin
        bus.deq_valid   = '0;
        bus.deq_inst    = '0;
        bus.deq_fsq_idx = '0;
        bus.deq_offset  = '0;
        bus.deq_ipf     = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            if (w_bypass) begin
                bus.deq_valid[k]   = NUM_W'(k) < bus.enq_num;
                bus.deq_inst[k]    = bus.enq_inst[k];
                bus.deq_fsq_idx[k] = bus.enq_fsq_idx;
                bus.deq_offset[k]  = bus.enq_offset[k];
                bus.deq_ipf[k]     = bus.enq_ipf;
            end else begin
                bus.deq_valid[k]   = (w_count > PTR_W'(k)) && !bus.flush;
                bus.deq_inst[k]    = r_inst[w_rd_idx[k]];
                bus.deq_fsq_idx[k] = r_fsq_idx[w_rd_idx[k]];
                bus.deq_offset[k]  = r_offset[w_rd_idx[k]];
                bus.deq_ipf[k]     = r_ipf[w_rd_idx[k]];
            end
        end
    end

    // Write accepted slots into storage; the FSQ index and page fault are shared by the block.
    // NOTE: entry storage has no reset -- validity is defined solely by head/tail, so clearing
    // the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (w_wr_en[i]) begin
                r_inst[w_wr_idx[i]]    <= bus.enq_inst[i];
                r_fsq_idx[w_wr_idx[i]] <= bus.enq_fsq_idx;
                r_offset[w_wr_idx[i]]  <= bus.enq_offset[i];
                r_ipf[w_wr_idx[i]]     <= bus.enq_ipf;
            end
        end
    end

    // Advance head on an accepted dequeue and tail on a fired enqueue; flush empties the FIFO.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (bus.flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (bus.deq_ready) begin
                r_head <= r_head + w_deq_num;
            end
            if (w_enq_fire) begin
                r_tail <= r_tail + PTR_W'(bus.enq_num) - PTR_W'(w_skip);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: a vector table drives per-cycle enqueue/dequeue/
// flush patterns with hand-derived count/full values, and a scoreboard queue of expected
// entries checks lane validity and contents. Builds with or without IBUF_BYPASS_EN.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 32;
    localparam int ENQ_W = 8;
    localparam int DEQ_W = 4;
    localparam int FSQ_W = 4;
    localparam int OFF_W = 4;

    typedef struct packed {
        logic [31:0]      inst;
        logic [FSQ_W-1:0] fsq;
        logic [OFF_W-1:0] off;
        logic             ipf;
    } ent_t;

    typedef struct {
        int               num;
        bit               rdy;
        bit               fl;
        logic [FSQ_W-1:0] fsq;
        bit               ipf;
        int               exp_count;   // occupancy seen before the clock edge
        bit               exp_full;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_buffer_if #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_W), .DEQ_WIDTH(DEQ_W),
                           .FSQ_WIDTH(FSQ_W), .OFF_WIDTH(OFF_W)) bus ();

    inst_fetch_buffer #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_W), .DEQ_WIDTH(DEQ_W),
                        .FSQ_WIDTH(FSQ_W), .OFF_WIDTH(OFF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t             sb [$];
    vec_t             vecs [$];
    logic [31:0]      stim_inst [ENQ_W];
    logic [OFF_W-1:0] stim_off  [ENQ_W];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input int num, input bit rdy, input bit fl, input int fsq, input bit ipf,
                       input int cnt, input bit full);
        vec_t v;
        v.num = num; v.rdy = rdy; v.fl = fl; v.fsq = FSQ_W'(fsq); v.ipf = ipf;
        v.exp_count = cnt; v.exp_full = full;
        vecs.push_back(v);
    endtask

    task automatic fill_words(input int seed);
        for (int i = 0; i < ENQ_W; i++) begin
            stim_inst[i] = {8'hC0, 8'(seed), 8'(i), 8'h13};
            stim_off[i]  = OFF_W'(seed + 3 * i);
        end
    endtask

    task automatic idle_inputs();
        bus.enq_en = '0; bus.enq_num = '0; bus.enq_inst = '0; bus.enq_fsq_idx = '0;
        bus.enq_offset = '0; bus.enq_ipf = 1'b0; bus.flush = 1'b0; bus.deq_ready = 1'b0;
    endtask

    // Drive one cycle (called at posedge+1), check pre-edge outputs, update the scoreboard.
    task automatic run_cycle(input vec_t v, input string tag);
        ent_t             lane [DEQ_W];
        int               nstore, nv, skip;
        bit               acc, byp;
        logic [DEQ_W-1:0] exp_valid;
        nstore = sb.size();
        bus.enq_num     = 4'(v.num);
        bus.enq_en      = ENQ_W'((1 << v.num) - 1);
        for (int i = 0; i < ENQ_W; i++) begin
            bus.enq_inst[i]   = stim_inst[i];
            bus.enq_offset[i] = stim_off[i];
        end
        bus.enq_fsq_idx = v.fsq;
        bus.enq_ipf     = v.ipf;
        bus.flush       = v.fl;
        bus.deq_ready   = v.rdy;
        acc = (v.num != 0) && ((DEPTH - nstore) >= ENQ_W) && !v.fl;
        byp = 1'b0;
`ifdef IBUF_BYPASS_EN
        byp = acc && (nstore == 0);
`endif
        if (v.fl)     nv = 0;
        else if (byp) nv = (v.num < DEQ_W) ? v.num : DEQ_W;
        else          nv = (nstore < DEQ_W) ? nstore : DEQ_W;
        for (int k = 0; k < nv; k++) begin
            lane[k] = byp ? ent_t'{stim_inst[k], v.fsq, stim_off[k], v.ipf} : sb[k];
        end
        exp_valid = DEQ_W'((1 << nv) - 1);
        #1;
        check({tag, " count"}, 64'(bus.count), 64'(v.exp_count));
        check({tag, " full"}, 64'(bus.full), 64'(v.exp_full));
        check({tag, " deq_valid"}, 64'(bus.deq_valid), 64'(exp_valid));
        for (int k = 0; k < nv; k++) begin
            check($sformatf("%s lane%0d", tag, k),
                  64'({bus.deq_inst[k], bus.deq_fsq_idx[k], bus.deq_offset[k], bus.deq_ipf[k]}),
                  64'(lane[k]));
        end
        if (v.fl) begin
            sb.delete();
        end else begin
            skip = 0;
            if (v.rdy) begin
                if (byp) skip = nv;
                else repeat (nv) void'(sb.pop_front());
            end
            if (acc) begin
                for (int i = skip; i < v.num; i++) begin
                    sb.push_back(ent_t'{stim_inst[i], v.fsq, stim_off[i], v.ipf});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef IBUF_BYPASS_EN
    localparam int BYP_LEFT = 2;
`else
    localparam int BYP_LEFT = 6;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //  num rdy fl fsq ipf | count full (before the edge)
        add(3, 0, 0, 2, 0,   0, 0);   // first enqueue after reset
        add(0, 1, 0, 0, 0,   3, 0);   // drain it, lanes 0..2
        add(8, 0, 0, 1, 0,   0, 0);   // fill
        add(8, 0, 0, 2, 1,   8, 0);
        add(8, 0, 0, 3, 0,  16, 0);
        add(8, 0, 0, 4, 0,  24, 0);   // 24 occupied leaves exactly 8 free: not full
        add(8, 0, 0, 5, 0,  32, 1);   // full: dropped
        add(0, 1, 0, 0, 0,  32, 1);
        add(3, 1, 0, 6, 0,  28, 1);   // still full: enqueue dropped, dequeue proceeds
        add(0, 0, 1, 0, 0,  24, 0);   // flush without enqueue
        add(8, 0, 0, 7, 0,   0, 0);   // 28 entries to move the pointers near the end
        add(8, 0, 0, 8, 1,   8, 0);
        add(8, 0, 0, 9, 0,  16, 0);
        add(4, 0, 0, 10, 0, 24, 0);
        add(0, 1, 0, 0, 0,  28, 1);
        add(0, 1, 0, 0, 0,  24, 0);
        add(0, 1, 0, 0, 0,  20, 0);
        add(0, 1, 0, 0, 0,  16, 0);
        add(0, 1, 0, 0, 0,  12, 0);
        add(0, 1, 0, 0, 0,   8, 0);
        add(0, 1, 0, 0, 0,   4, 0);
        add(8, 0, 0, 11, 1,  0, 0);   // wraps: entries 28..31 then 0..3
        add(0, 1, 0, 0, 0,   8, 0);
        add(0, 1, 0, 0, 0,   4, 0);
        add(6, 0, 0, 12, 0,  0, 0);
        add(5, 1, 0, 13, 0,  6, 0);   // simultaneous enq 5 / deq 4
        add(0, 1, 0, 0, 0,   7, 0);
        add(7, 0, 0, 14, 0,  3, 0);
        add(8, 1, 1, 15, 0, 10, 0);   // flush with enqueue: lanes forced off, enqueue dropped
        add(0, 0, 0, 0, 0,   0, 0);
        add(2, 0, 0, 3, 1,   0, 0);
        add(0, 1, 0, 0, 0,   2, 0);   // partial lanes 0..1

        idle_inputs();
        fill_words(0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset count", 64'(bus.count), 64'd0);
        check("reset full", 64'(bus.full), 64'd0);
        check("reset deq_valid", 64'(bus.deq_valid), 64'd0);
        rst = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            if (n == 0) begin
                fill_words(0);
                stim_inst[0] = 32'h13; stim_inst[1] = 32'h33; stim_inst[2] = 32'h63;
            end else begin
                fill_words(n);
            end
            run_cycle(vecs[n], $sformatf("v%0d", n));
            if (n == 0) begin
                check("first lane0 inst", 64'(bus.deq_inst[0]), 64'h13);
                check("first lane0 fsq", 64'(bus.deq_fsq_idx[0]), 64'd2);
            end
        end

        // Asynchronous reset in the middle of a cycle clears the occupancy at once.
        fill_words(40);
        v = '{num: 5, rdy: 0, fl: 0, fsq: 4'd9, ipf: 0, exp_count: 0, exp_full: 0};
        run_cycle(v, "pre_rst");
        idle_inputs();
        #1;
        rst = 1'b0;
        #1;
        check("mid rst count", 64'(bus.count), 64'd0);
        check("mid rst deq_valid", 64'(bus.deq_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Enqueue 6 into an empty buffer with decode ready.
        fill_words(50);
        v = '{num: 6, rdy: 1, fl: 0, fsq: 4'd3, ipf: 0, exp_count: 0, exp_full: 0};
        run_cycle(v, "byp");
        check("byp next count", 64'(bus.count), 64'(BYP_LEFT));
        fill_words(51);
        v = '{num: 0, rdy: 1, fl: 0, fsq: 4'd0, ipf: 0, exp_count: BYP_LEFT, exp_full: 0};
        run_cycle(v, "byp_drain0");
        v.exp_count = (BYP_LEFT > DEQ_W) ? BYP_LEFT - DEQ_W : 0;
        run_cycle(v, "byp_drain1");
        idle_inputs();
        #1;
        check("end count", 64'(bus.count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
